weight_bram_seq_ctrl: RTL and testbench

//  Controller for one 16-bit x 28-entry neuron weight BRAM. The BRAM reads and writes on negedge CLK.
//  - Streams weights 0..DEPTH-1 to a MAC datapath over a valid/ready interface.
//  - Arbitrates the single BRAM port between that read sequence and a weight-load write port.
//  - Pulses DONE once the last weight has been consumed.

---
 rtl/weight_bram_seq_ctrl.sv | 149 ++++++++++++++
 tb/tb_weight_bram_seq_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/weight_bram_seq_ctrl.sv
// Weight BRAM sequencer: streams DEPTH words to a MAC over valid/ready and shares the BRAM port with a load port.
// Optional WSEQ_BOUNDS_CHECK_EN drops out-of-range loads and raises a sticky LD_ERR.
module weight_bram_seq_ctrl #(
  parameter int DEPTH = 28,
  parameter int AW    = 5,
  parameter int DW    = 16
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  output logic          BUSY,
  output logic          DONE,
  output logic [DW-1:0] W_DATA,
  output logic          W_VALID,
  output logic          W_LAST,
  input  logic          W_READY,
  input  logic          LD_VALID,
  output logic          LD_READY,
  input  logic [AW-1:0] LD_ADDR,
  input  logic [DW-1:0] LD_DATA,
  output logic [AW-1:0] BRAM_ADDR,
  output logic [DW-1:0] BRAM_DI,
  output logic          BRAM_EN,
  output logic          BRAM_WE,
  input  logic [DW-1:0] BRAM_DO
`ifdef WSEQ_BOUNDS_CHECK_EN
  ,
  output logic          LD_ERR
`endif
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_rd_cnt;
  logic          r_infl;
  logic          r_done;
  logic [DW-1:0] r_w_data;
  logic          r_w_valid;
  logic          r_w_last;
  logic [AW-1:0] r_bram_addr;
  logic [DW-1:0] r_bram_di;
  logic          r_bram_en;
  logic          r_bram_we;

  logic w_slot_free;
  logic w_issue;
  logic w_ld_acc;
  logic w_ld_wr;
  logic w_done_nxt;

  assign w_slot_free = !r_w_valid || W_READY;

`ifdef WSEQ_BOUNDS_CHECK_EN
  logic r_ld_err;
  logic w_oob;
  assign w_oob   = {{(32-AW){1'b0}}, LD_ADDR} >= 32'(DEPTH);
  assign w_ld_wr = w_ld_acc && !w_oob;
  assign LD_ERR  = r_ld_err;
`else
  assign w_ld_wr = w_ld_acc;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_ld_acc    = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (START)         w_state_nxt = READ;
        else if (LD_VALID) w_ld_acc    = 1'b1;
      end
      READ: begin
        // A stalled in-flight word keeps BRAM_DO valid as long as no new read is issued.
        w_issue = w_slot_free;
        if (w_issue && r_rd_cnt == LAST_ADDR) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (r_w_valid && W_READY && r_w_last) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= IDLE;
      r_rd_cnt    <= '0;
      r_infl      <= 1'b0;
      r_done      <= 1'b0;
      r_w_data    <= '0;
      r_w_valid   <= 1'b0;
      r_w_last    <= 1'b0;
      r_bram_addr <= '0;
      r_bram_di   <= '0;
      r_bram_en   <= 1'b0;
      r_bram_we   <= 1'b0;
`ifdef WSEQ_BOUNDS_CHECK_EN
      r_ld_err    <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_done    <= w_done_nxt;
      r_infl    <= w_issue || (r_infl && !w_slot_free);
      r_bram_en <= w_issue || w_ld_wr;
      r_bram_we <= w_ld_wr;

      if (r_state == IDLE && START)             r_rd_cnt <= '0;
      else if (w_issue && r_rd_cnt != LAST_ADDR) r_rd_cnt <= r_rd_cnt + 1'b1;

      if (w_issue) begin
        r_bram_addr <= r_rd_cnt;
      end else if (w_ld_wr) begin
        r_bram_addr <= LD_ADDR;
        r_bram_di   <= LD_DATA;
      end

      if (r_infl && w_slot_free) begin
        r_w_data  <= BRAM_DO;
        r_w_valid <= 1'b1;
        r_w_last  <= (r_bram_addr == LAST_ADDR);
      end else if (W_READY) begin
        r_w_valid <= 1'b0;
        r_w_last  <= 1'b0;
      end
`ifdef WSEQ_BOUNDS_CHECK_EN
      if (w_ld_acc && w_oob) r_ld_err <= 1'b1;
`endif
    end
  end

  assign BUSY      = (r_state != IDLE);
  assign LD_READY  = (r_state == IDLE) && !START;
  assign DONE      = r_done;
  assign W_DATA    = r_w_data;
  assign W_VALID   = r_w_valid;
  assign W_LAST    = r_w_last;
  assign BRAM_ADDR = r_bram_addr;
  assign BRAM_DI   = r_bram_di;
  assign BRAM_EN   = r_bram_en;
  assign BRAM_WE   = r_bram_we;

endmodule

// File: tb/tb_weight_bram_seq_ctrl.sv
// Scoreboard bench for weight_bram_seq_ctrl with a negedge BRAM model.
module tb_weight_bram_seq_ctrl;
  localparam int DEPTH = 28;
  localparam int AW    = 5;
  localparam int DW    = 16;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          START = 1'b0;
  logic          W_READY = 1'b1;
  logic          LD_VALID = 1'b0;
  logic [AW-1:0] LD_ADDR = '0;
  logic [DW-1:0] LD_DATA = '0;
  logic [DW-1:0] BRAM_DO = '0;
  logic          BUSY, DONE, W_VALID, W_LAST, LD_READY, BRAM_EN, BRAM_WE;
  logic [DW-1:0] W_DATA, BRAM_DI;
  logic [AW-1:0] BRAM_ADDR;
`ifdef WSEQ_BOUNDS_CHECK_EN
  logic          LD_ERR;
`endif

  int total = 0;
  int bad = 0;
  int pop_cnt = 0;
  int done_cnt = 0;
  int wr_cnt = 0;

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] exp_mem [DEPTH];
  logic [DW:0]   exp_q [$];

  weight_bram_seq_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .CLK(CLK), .RST(RST), .START(START), .BUSY(BUSY), .DONE(DONE),
    .W_DATA(W_DATA), .W_VALID(W_VALID), .W_LAST(W_LAST), .W_READY(W_READY),
    .LD_VALID(LD_VALID), .LD_READY(LD_READY), .LD_ADDR(LD_ADDR), .LD_DATA(LD_DATA),
    .BRAM_ADDR(BRAM_ADDR), .BRAM_DI(BRAM_DI), .BRAM_EN(BRAM_EN), .BRAM_WE(BRAM_WE),
    .BRAM_DO(BRAM_DO)
`ifdef WSEQ_BOUNDS_CHECK_EN
    , .LD_ERR(LD_ERR)
`endif
  );

  always #5 CLK = ~CLK;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
    end
  endfunction

  // BRAM model: read and write on negedge
  always @(negedge CLK) begin
    if (BRAM_EN) begin
      if (BRAM_WE) begin
        mem[BRAM_ADDR] <= BRAM_DI;
        wr_cnt <= wr_cnt + 1;
      end else begin
        BRAM_DO <= mem[BRAM_ADDR];
      end
    end
  end

  // Monitor: pop expected word on each handshake, check holds and DONE timing
  logic          prev_stall = 1'b0;
  logic          prev_lhs = 1'b0;
  logic          prev_last = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic [DW:0]   e;
  always @(negedge CLK) begin
    if (!RST) begin
      if (prev_stall) chk("hold_on_stall", {W_VALID, W_LAST, W_DATA}, {1'b1, prev_last, prev_data});
      if (W_VALID && W_READY) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", {W_LAST, W_DATA}, {1'b1, 1'bx, 16'hxxxx});
        end else begin
          e = exp_q.pop_front();
          chk("word", {W_LAST, W_DATA}, e);
        end
        pop_cnt <= pop_cnt + 1;
      end
      if (DONE || prev_lhs) chk("done_pulse", DONE, prev_lhs);
      if (DONE) done_cnt <= done_cnt + 1;
    end
    prev_stall <= !RST && W_VALID && !W_READY;
    prev_lhs   <= !RST && W_VALID && W_READY && W_LAST;
    prev_last  <= W_LAST;
    prev_data  <= W_DATA;
  end

  // Called at posedge+1. Ends at negedge+1 of the DONE cycle, or at posedge+1 after a reset.
  task automatic run_pass(input bit tog, input int restart_at, input int rst_at, output int cyc);
    int  base;
    int  d0;
    bit  fired;
    base  = pop_cnt;
    d0    = done_cnt;
    fired = 1'b0;
    for (int k = 0; k < DEPTH; k++) exp_q.push_back({(k == DEPTH-1) ? 1'b1 : 1'b0, exp_mem[k]});
    START = 1'b1;
    #1;
    chk("ld_ready_vs_start", LD_READY, 0);
    @(posedge CLK); #1;
    START = 1'b0;
    cyc = 1;
    while (!DONE && cyc < 400) begin
      START = 1'b0;
      if (rst_at >= 0 && pop_cnt - base >= rst_at) begin
        RST = 1'b1;
        exp_q.delete();
        @(posedge CLK); #1;
        RST = 1'b0;
        chk("rst_outs", {BUSY, DONE, W_VALID, W_LAST, W_DATA, BRAM_EN, BRAM_WE, BRAM_ADDR, BRAM_DI}, 0);
        chk("rst_ld_ready", LD_READY, 1);
        fired = 1'b1;
        break;
      end
      if (restart_at >= 0 && !fired && pop_cnt - base == restart_at) begin
        START = 1'b1;
        fired = 1'b1;
      end
      if (tog) W_READY = ~W_READY;
      @(posedge CLK); #1;
      cyc++;
    end
    START   = 1'b0;
    W_READY = 1'b1;
    if (rst_at < 0) begin
      chk("pass_done", DONE, 1);
      chk("busy_at_done", BUSY, 0);
      @(negedge CLK); #1;
      chk("words_left", exp_q.size(), 0);
      chk("done_count", done_cnt - d0, 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int w0;
    int d0;
    for (int i = 0; i < 2**AW; i++) mem[i] = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_outs", {BUSY, DONE, W_VALID, W_LAST, W_DATA, BRAM_EN, BRAM_WE, BRAM_ADDR, BRAM_DI}, 0);
    RST = 1'b0;
    @(posedge CLK); #1;
    chk("idle_ld_ready", LD_READY, 1);

    // Back-to-back preload addr k = 3k
    for (int k = 0; k < DEPTH; k++) begin
      LD_VALID   = 1'b1;
      LD_ADDR    = AW'(k);
      LD_DATA    = DW'(k * 3);
      exp_mem[k] = DW'(k * 3);
      @(posedge CLK); #1;
      chk("load_issue", {BRAM_EN, BRAM_WE, BRAM_ADDR, BRAM_DI}, {2'b11, AW'(k), DW'(k * 3)});
    end
    LD_VALID = 1'b0;
    @(posedge CLK); #1;
    chk("load_one_cycle", {BRAM_EN, BRAM_WE}, 2'b00);
    chk("load_write_count", wr_cnt, DEPTH);

    // Full-rate pass
    run_pass(1'b0, -1, -1, cyc);
    chk("pass_latency", cyc, 31);

    // W_READY toggling
    run_pass(1'b1, -1, -1, cyc);

    // START beats LD_VALID; load lands once idle
    LD_VALID = 1'b1;
    LD_ADDR  = 5'd3;
    LD_DATA  = 16'h1234;
    w0 = wr_cnt;
    run_pass(1'b0, -1, -1, cyc);
    chk("no_write_while_busy", wr_cnt, w0);
    @(posedge CLK); #1;
    LD_VALID = 1'b0;
    chk("late_load_issue", {BRAM_EN, BRAM_WE, BRAM_ADDR, BRAM_DI}, {2'b11, 5'd3, 16'h1234});
    exp_mem[3] = 16'h1234;
    @(posedge CLK); #1;
    chk("late_load_written", wr_cnt, w0 + 1);
    run_pass(1'b0, -1, -1, cyc);

    // Reset at word 10, then a fresh full pass
    @(posedge CLK); #1;
    d0 = done_cnt;
    run_pass(1'b0, -1, 10, cyc);
    repeat (3) @(posedge CLK);
    #1;
    chk("no_done_after_rst", done_cnt, d0);
    chk("idle_after_rst", BUSY, 0);
    run_pass(1'b0, -1, -1, cyc);
    chk("fresh_pass_latency", cyc, 31);

    // START while busy is ignored
    @(posedge CLK); #1;
    run_pass(1'b0, 5, -1, cyc);
    chk("restart_ignored_latency", cyc, 31);
    repeat (2) @(posedge CLK);
    #1;
    chk("restart_no_second_pass", BUSY, 0);

`ifdef WSEQ_BOUNDS_CHECK_EN
    w0 = wr_cnt;
    LD_VALID = 1'b1;
    LD_ADDR  = 5'd30;
    LD_DATA  = 16'hBEEF;
    #1;
    chk("oob_ld_ready", LD_READY, 1);
    @(posedge CLK); #1;
    LD_VALID = 1'b0;
    chk("oob_no_write", {BRAM_EN, LD_ERR}, 2'b01);
    @(posedge CLK); #1;
    chk("oob_write_count", wr_cnt, w0);
    run_pass(1'b0, -1, -1, cyc);
    chk("ld_err_sticky", LD_ERR, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
